mmio_initiator: RTL and testbench



---
 rtl/mmio_initiator.sv | 210 +++++++++++++++++++++
 tb/tb_mmio_initiator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_initiator.sv
// mmio_initiator
//   Bus-master end of the core's MMIO load/store path. Accepts one request
//   from the MEM stage, drives the device strobes, waits for the device's
//   valid (or a timeout), and returns aligned and extended load data, or an
//   error, as a one-cycle response. The pipeline is stalled while the
//   request is outstanding.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_*             request from the pipeline (valid/ready handshake)
//   resp_*            one-cycle response pulse: data, error
//   stall_o           pipeline stall
//   address_o/indata_o/wen_o/ren_o/mask_o   device-side strobes
//   outdata_i/valid_i device read data and completion
module mmio_initiator #(
   parameter int TIMEOUT   = 16,
   parameter int BUS_BYTES = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [63:0]              req_addr_i,
   input  logic [BUS_BYTES*8-1:0]   req_wdata_i,
   input  logic [1:0]               req_size_i,
   input  logic                     req_unsigned_i,
   output logic                     resp_valid_o,
   output logic [BUS_BYTES*8-1:0]   resp_rdata_o,
   output logic                     resp_err_o,
   output logic                     stall_o,
   output logic [63:0]              address_o,
   output logic [BUS_BYTES*8-1:0]   indata_o,
   output logic                     wen_o,
   output logic                     ren_o,
   output logic [BUS_BYTES-1:0]     mask_o,
   input  logic [BUS_BYTES*8-1:0]   outdata_i,
   input  logic                     valid_i
);

   localparam int DW = BUS_BYTES * 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 we_q, we_d;
   logic [2:0]           off_q, off_d;
   logic [1:0]           size_q, size_d;
   logic                 uns_q, uns_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [63:0]          address_q, address_d;
   logic [DW-1:0]        indata_q, indata_d;
   logic [BUS_BYTES-1:0] mask_q, mask_d;
   logic                 wen_q, wen_d;
   logic                 ren_q, ren_d;
   logic                 resp_valid_q, resp_valid_d;
   logic                 resp_err_q, resp_err_d;
   logic [DW-1:0]        resp_rdata_q, resp_rdata_d;

   logic                 misaligned;
   logic [BUS_BYTES-1:0] mask_base;
   logic [DW-1:0]        rd_shift;
   logic [DW-1:0]        rd_ext;

   // Alignment of the incoming request.
   always_comb begin
      misaligned = 1'b0;
      mask_base  = '0;
      case (req_size_i)
         2'd0: begin misaligned = 1'b0;             mask_base = BUS_BYTES'(8'h01); end
         2'd1: begin misaligned = req_addr_i[0];    mask_base = BUS_BYTES'(8'h03); end
         2'd2: begin misaligned = |req_addr_i[1:0]; mask_base = BUS_BYTES'(8'h0F); end
         default: begin misaligned = |req_addr_i[2:0]; mask_base = BUS_BYTES'(8'hFF); end
      endcase
   end

   // Move the addressed lane down to bit 0, then truncate and extend.
   always_comb begin
      rd_shift = outdata_i >> {off_q, 3'b000};
      rd_ext   = rd_shift;
      case (size_q)
         2'd0: rd_ext = uns_q ? {{(DW-8){1'b0}},  rd_shift[7:0]}
                              : {{(DW-8){rd_shift[7]}},  rd_shift[7:0]};
         2'd1: rd_ext = uns_q ? {{(DW-16){1'b0}}, rd_shift[15:0]}
                              : {{(DW-16){rd_shift[15]}}, rd_shift[15:0]};
         2'd2: rd_ext = uns_q ? {{(DW-32){1'b0}}, rd_shift[31:0]}
                              : {{(DW-32){rd_shift[31]}}, rd_shift[31:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      cnt_d        = cnt_q;
      address_d    = address_q;
      indata_d     = indata_q;
      mask_d       = mask_q;
      wen_d        = wen_q;
      ren_d        = ren_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               we_d   = req_we_i;
               off_d  = req_addr_i[2:0];
               size_d = req_size_i;
               uns_d  = req_unsigned_i;
               if (misaligned) begin
                  // Never reaches the bus; report straight away.
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d   = S_ISSUE;
                  cnt_d     = '0;
                  address_d = {req_addr_i[63:3], 3'b000};
                  mask_d    = mask_base << req_addr_i[2:0];
                  indata_d  = req_wdata_i << {req_addr_i[2:0], 3'b000};
                  wen_d     = req_we_i;
                  ren_d     = ~req_we_i;
               end
            end
         end

         S_ISSUE, S_WAIT: begin
            if (valid_i) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? '0 : rd_ext;
            end else if (state_q == S_ISSUE) begin
               state_d = S_WAIT;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
            // Leaving the bus phase: release every strobe together.
            if (state_d == S_RESP) begin
               wen_d     = 1'b0;
               ren_d     = 1'b0;
               mask_d    = '0;
               address_d = '0;
               indata_d  = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         cnt_q        <= '0;
         address_q    <= '0;
         indata_q     <= '0;
         mask_q       <= '0;
         wen_q        <= 1'b0;
         ren_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         cnt_q        <= cnt_d;
         address_q    <= address_d;
         indata_q     <= indata_d;
         mask_q       <= mask_d;
         wen_q        <= wen_d;
         ren_q        <= ren_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign stall_o      = (state_q == S_IDLE) ? req_valid_i : (state_q != S_RESP);
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;
   assign address_o    = address_q;
   assign indata_o     = indata_q;
   assign mask_o       = mask_q;
   assign wen_o        = wen_q;
   assign ren_o        = ren_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator. A device model answers the strobes
// after a programmable delay; requests push their expected response (data,
// error, cycle) into a scoreboard that an independent monitor pops.
module tb_mmio_initiator;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [63:0] req_addr_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic [1:0]  req_size_i = '0;
   logic        req_unsigned_i = 1'b0;
   logic        resp_valid_o;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;
   logic        stall_o;
   logic [63:0] address_o;
   logic [63:0] indata_o;
   logic        wen_o;
   logic        ren_o;
   logic [7:0]  mask_o;
   logic [63:0] outdata_i = '0;
   logic        valid_i = 1'b0;

   mmio_initiator #(.TIMEOUT(T), .BUS_BYTES(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
      .resp_err_o(resp_err_o), .stall_o(stall_o),
      .address_o(address_o), .indata_o(indata_o),
      .wen_o(wen_o), .ren_o(ren_o), .mask_o(mask_o),
      .outdata_i(outdata_i), .valid_i(valid_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          cyc;
      int          id;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Device model
   int          dev_dly = 0;
   bit          dev_never = 1'b0;
   bit          dev_spur = 1'b0;
   int          scnt = 0;
   int          wen_tot = 0, ren_tot = 0, stab_err = 0;
   logic [63:0] cap_addr = '0, cap_idata = '0;
   logic [7:0]  cap_mask = '0;

   always @(negedge clk) begin
      if (wen_o || ren_o) begin
         scnt = scnt + 1;
         if (scnt == 1) begin
            cap_addr  = address_o;
            cap_mask  = mask_o;
            cap_idata = indata_o;
         end else if (address_o !== cap_addr || mask_o !== cap_mask || indata_o !== cap_idata) begin
            stab_err = stab_err + 1;
         end
         if (wen_o && ren_o) stab_err = stab_err + 1;
         if (wen_o) wen_tot = wen_tot + 1;
         if (ren_o) ren_tot = ren_tot + 1;
         valid_i = !dev_never && (scnt > dev_dly);
      end else begin
         scnt = 0;
         valid_i = dev_spur;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst && resp_valid_o) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=resp_valid at cyc %0d expected=none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("resp%0d_cycle", e.id), 64'(cyc), 64'(e.cyc));
            chk($sformatf("resp%0d_err", e.id), {63'd0, resp_err_o}, {63'd0, e.err});
            chk($sformatf("resp%0d_rdata", e.id), resp_rdata_o, e.rdata);
         end
      end
   end

   int id = 0;

   task automatic do_req(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input bit uns, input int dly, input bit never,
                         input logic [63:0] dev_data, input logic [63:0] exp_rdata,
                         input bit exp_err, input int lat, input int stb,
                         input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                         input logic [63:0] exp_idata, output int acc);
      int w0, r0, s0;
      bit ok;
      id++;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL req%0d_ready actual=0 expected=1", id);
      end
      w0 = wen_tot; r0 = ren_tot; s0 = stab_err;
      dev_dly = dly; dev_never = never; outdata_i = dev_data;
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
      req_size_i = size; req_unsigned_i = uns;
      #1 chk($sformatf("req%0d_stall", id), {63'd0, stall_o}, 64'd1);
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid_i = 1'b0;
      sb.push_back('{rdata: exp_rdata, err: exp_err, cyc: acc + lat, id: id});
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL req%0d_resp_timeout actual=no_resp expected=resp", id);
         sb.delete();
      end
      chk($sformatf("req%0d_wen_cycles", id), 64'(wen_tot - w0), 64'(we ? stb : 0));
      chk($sformatf("req%0d_ren_cycles", id), 64'(ren_tot - r0), 64'(we ? 0 : stb));
      chk($sformatf("req%0d_stable", id), 64'(stab_err - s0), 64'd0);
      if (stb > 0) begin
         chk($sformatf("req%0d_address", id), cap_addr, exp_addr);
         chk($sformatf("req%0d_mask", id), {56'd0, cap_mask}, {56'd0, exp_mask});
         chk($sformatf("req%0d_indata", id), cap_idata, exp_idata);
      end
   endtask

   initial begin
      int a, a2;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_wen", {63'd0, wen_o}, 64'd0);
      chk("rst_ren", {63'd0, ren_o}, 64'd0);
      chk("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
      chk("rst_resp_err", {63'd0, resp_err_o}, 64'd0);
      chk("rst_mask", {56'd0, mask_o}, 64'd0);
      chk("rst_address", address_o, 64'd0);
      chk("rst_indata", indata_o, 64'd0);
      chk("rst_rdata", resp_rdata_o, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", {63'd0, req_ready_o}, 64'd1);
      chk("idle_stall", {63'd0, stall_o}, 64'd0);

      // Stray device valid while idle must be ignored
      dev_spur = 1'b1;
      repeat (4) @(negedge clk);
      dev_spur = 1'b0;

      // sd / lw / lbu / lb
      do_req(1, 64'h02004000, 64'h1234, 2'd3, 0, 0, 0, 64'h0, 64'h0, 0, 1, 1,
             64'h02004000, 8'hFF, 64'h1234, a);
      do_req(0, 64'h02004004, 64'h0, 2'd2, 0, 0, 0, 64'h80000001_00000000,
             64'hFFFFFFFF_80000001, 0, 1, 1, 64'h02004000, 8'hF0, 64'h0, a);
      do_req(0, 64'h0200BFFF, 64'h0, 2'd0, 1, 0, 0, 64'hAB00_0000_0000_0000,
             64'hAB, 0, 1, 1, 64'h0200BFF8, 8'h80, 64'h0, a);
      do_req(0, 64'h0200BFFF, 64'h0, 2'd0, 0, 0, 0, 64'hAB00_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFAB, 0, 1, 1, 64'h0200BFF8, 8'h80, 64'h0, a);
      // Misaligned: sh, lw, ld
      do_req(1, 64'h02004003, 64'hBEEF, 2'd1, 0, 0, 0, 64'h0, 64'h0, 1, 0, 0,
             64'h0, 8'h0, 64'h0, a);
      do_req(0, 64'h02004006, 64'h0, 2'd2, 0, 0, 0, 64'h0, 64'h0, 1, 0, 0,
             64'h0, 8'h0, 64'h0, a);
      do_req(0, 64'h02004004, 64'h0, 2'd3, 0, 0, 0, 64'h0, 64'h0, 1, 0, 0,
             64'h0, 8'h0, 64'h0, a);
      // Delayed device responses
      do_req(0, 64'h02004002, 64'h0, 2'd1, 0, 2, 0, 64'h00000000_80010000,
             64'hFFFF_FFFF_FFFF_8001, 0, 3, 3, 64'h02004000, 8'h0C, 64'h0, a);
      do_req(0, 64'h02004002, 64'h0, 2'd1, 1, 1, 0, 64'h00000000_80010000,
             64'h8001, 0, 2, 2, 64'h02004000, 8'h0C, 64'h0, a);
      do_req(1, 64'h0200400C, 64'hCAFEF00D, 2'd2, 0, 1, 0, 64'h0, 64'h0, 0, 2, 2,
             64'h02004008, 8'hF0, 64'hCAFEF00D_00000000, a);
      do_req(0, 64'h02004008, 64'h0, 2'd3, 1, 0, 0, 64'h81234567_89ABCDEF,
             64'h81234567_89ABCDEF, 0, 1, 1, 64'h02004008, 8'hFF, 64'h0, a);
      do_req(0, 64'h02004000, 64'h0, 2'd2, 1, 0, 0, 64'h12345678_9ABCDEF0,
             64'h00000000_9ABCDEF0, 0, 1, 1, 64'h02004000, 8'h0F, 64'h0, a);
      // Timeout, then a back-to-back sb
      do_req(0, 64'h02004008, 64'h0, 2'd3, 0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF,
             64'h0, 1, 1 + T, T + 1, 64'h02004008, 8'hFF, 64'h0, a);
      do_req(1, 64'h02004005, 64'h5A, 2'd0, 0, 0, 0, 64'h0, 64'h0, 0, 1, 1,
             64'h02004000, 8'h20, 64'h00005A00_00000000, a2);
      chk("b2b_accept_cycle", 64'(a2 - a), 64'd19);

      // Reset in the middle of WAIT aborts without a response
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready_o) break;
      end
      dev_dly = 3; dev_never = 1'b0; outdata_i = 64'h1;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 64'h02004010;
      req_size_i = 2'd3; req_unsigned_i = 1'b0;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_ren_before", {63'd0, ren_o}, 64'd1);
      chk("abort_stall_before", {63'd0, stall_o}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ren", {63'd0, ren_o}, 64'd0);
      chk("abort_wen", {63'd0, wen_o}, 64'd0);
      chk("abort_mask", {56'd0, mask_o}, 64'd0);
      chk("abort_resp_valid", {63'd0, resp_valid_o}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", {63'd0, req_ready_o}, 64'd1);
      repeat (8) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
